// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider: FSM states and the
// ready / stall / signedness levels used on its handshake lines.
package div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } div_state_e;

    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic DIV_SIGNED   = 1'b1;
    localparam logic DIV_UNSIGNED = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider producing {remainder, quotient};
// raises a combinational stall request while a division is outstanding.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_annul,
    input  logic                 i_signed_div,
    input  logic [WIDTH-1:0]     i_opdata1,
    input  logic [WIDTH-1:0]     i_opdata2,
    output logic [2*WIDTH-1:0]   o_result,
    output logic                 o_ready,
    output logic                 o_stallreq
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    div_state_e           state_reg, state_next;
    logic [2*WIDTH:0]     working_reg, working_next;
    logic [CW-1:0]        counter_reg, counter_next;
    logic [WIDTH-1:0]     divisor_reg, divisor_next;
    logic                 signed_reg, signed_next;
    logic                 sign1_reg, sign1_next;
    logic                 sign2_reg, sign2_next;
    logic [2*WIDTH-1:0]   result_reg, result_next;
    logic                 ready_reg, ready_next;

    logic [WIDTH-1:0]     dividend_abs;
    logic [WIDTH-1:0]     divisor_abs;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Magnitudes are only formed for signed requests with a negative operand.
    assign dividend_abs = (i_signed_div == DIV_SIGNED && i_opdata1[WIDTH-1]) ? -i_opdata1 : i_opdata1;
    assign divisor_abs  = (i_signed_div == DIV_SIGNED && i_opdata2[WIDTH-1]) ? -i_opdata2 : i_opdata2;

    // Trial subtraction of the divisor from the upper WIDTH+1 bits; MSB set means negative.
    assign diff = working_reg[2*WIDTH:WIDTH] - {1'b0, divisor_reg};

    assign quo_fix = (signed_reg == DIV_SIGNED && (sign1_reg ^ sign2_reg))
                     ? -working_reg[WIDTH-1:0] : working_reg[WIDTH-1:0];
    assign rem_fix = (signed_reg == DIV_SIGNED && sign1_reg)
                     ? -working_reg[2*WIDTH:WIDTH+1] : working_reg[2*WIDTH:WIDTH+1];

    always_comb begin
        state_next   = state_reg;
        working_next = working_reg;
        counter_next = counter_reg;
        divisor_next = divisor_reg;
        signed_next  = signed_reg;
        sign1_next   = sign1_reg;
        sign2_next   = sign2_reg;
        result_next  = result_reg;
        ready_next   = ready_reg;

        case (state_reg)
            IDLE: begin
                if (i_start && !i_annul) begin
                    if (i_opdata2 == '0) begin
                        state_next = BYZERO;
                    end else begin
                        state_next   = ON;
                        signed_next  = i_signed_div;
                        sign1_next   = i_opdata1[WIDTH-1];
                        sign2_next   = i_opdata2[WIDTH-1];
                        divisor_next = divisor_abs;
                        working_next = {{WIDTH{1'b0}}, dividend_abs, 1'b0};
                        counter_next = '0;
                    end
                end
            end
            BYZERO: begin
                working_next = '0;
                state_next   = END;
            end
            ON: begin
                if (i_annul) begin
                    state_next = IDLE;
                end else if (counter_reg != CNT_LAST) begin
                    if (diff[WIDTH]) begin
                        working_next = {working_reg[2*WIDTH-1:0], 1'b0};
                    end else begin
                        working_next = {diff[WIDTH-1:0], working_reg[WIDTH-1:0], 1'b1};
                    end
                    counter_next = counter_reg + CW'(1);
                end else begin
                    // Sign fix-up cycle: remainder keeps its upper-field position.
                    working_next = {rem_fix, 1'b0, quo_fix};
                    state_next   = END;
                end
            end
            END: begin
                if (i_annul || !i_start) begin
                    state_next  = IDLE;
                    ready_next  = DIV_NOT_READY;
                    result_next = '0;
                end else begin
                    ready_next  = DIV_READY;
                    result_next = {working_reg[2*WIDTH:WIDTH+1], working_reg[WIDTH-1:0]};
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            working_reg <= '0;
            counter_reg <= '0;
            divisor_reg <= '0;
            signed_reg  <= DIV_UNSIGNED;
            sign1_reg   <= 1'b0;
            sign2_reg   <= 1'b0;
            result_reg  <= '0;
            ready_reg   <= DIV_NOT_READY;
        end else begin
            state_reg   <= state_next;
            working_reg <= working_next;
            counter_reg <= counter_next;
            divisor_reg <= divisor_next;
            signed_reg  <= signed_next;
            sign1_reg   <= sign1_next;
            sign2_reg   <= sign2_next;
            result_reg  <= result_next;
            ready_reg   <= ready_next;
        end
    end

    assign o_result   = result_reg;
    assign o_ready    = ready_reg;
    assign o_stallreq = (i_start && !i_annul && ready_reg != DIV_READY) ? STOP : NOSTOP;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the EX stage: signed/unsigned DIV/DIVU, producing {remainder, quotient} for HI/LO.
- It is the requesting end of the pipeline stall protocol. While a division is in flight it drives `o_stallreq`; EX forwards this to the pause controller as its EX stall request.
- Consumes `i_annul` so a flushed divide is abandoned.

Parameters:
- `WIDTH`, default 32, operand width in bits. Result is 2*WIDTH.

Ports:
- `i_clk`  input  1  clock
- `i_rst`  input  1  reset, synchronous, active-high
- `i_start`  input  1  EX holds a DIV/DIVU request; held high until `o_ready` is seen
- `i_annul`  input  1  cancel the current/pending division (pipeline flush)
- `i_signed_div`  input  1  1 = signed DIV, 0 = DIVU
- `i_opdata1`  input  WIDTH  dividend
- `i_opdata2`  input  WIDTH  divisor
- `o_result`  output  2*WIDTH  {remainder, quotient}; valid only while `o_ready`
- `o_ready`  output  1  result valid
- `o_stallreq`  output  1  stall request to the pause controller (STOP level = 1)

Behaviour:
- Reset, also when asserted mid-division:
  - state goes to IDLE.
  - `o_result` = 0, `o_ready` = 0, counter = 0, working register = 0.
  - `o_stallreq` follows its combinational rule.
- `o_stallreq` = `i_start` & ~`i_annul` & ~`o_ready`. It is combinational so the stall reaches the pause controller in the issuing cycle.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - `i_start` & ~`i_annul` accepts the request at edge T.
  - Divisor == 0: go to BYZERO.
  - Otherwise go to ON. Latch the signed flag, the operand sign bits and |divisor|. Working register (2*WIDTH+1 bits) = {WIDTH zeros, |dividend|, 1'b0}. Counter = 0.
  - Absolute values are taken only when signed and the MSB is set (two's-complement negate).
  - Operands are sampled only at acceptance; later input changes are ignored.
- BYZERO: working register = 0, go to END. Result is 0, with `o_ready` at T+2.
- ON:
  - `i_annul` has priority: go to IDLE next edge, no result, `o_ready` stays 0.
  - While counter != WIDTH:
    - diff = upper WIDTH+1 bits − {0, |divisor|}.
    - If diff is negative: shift left by 1, inserting 0.
    - Otherwise: load {diff[WIDTH-1:0], lower bits, 1}.
    - Counter++.
  - At counter == WIDTH, one fix-up cycle, then go to END:
    - quotient = low WIDTH bits, negated if signed & (sign1 ^ sign2).
    - remainder = working[2*WIDTH:WIDTH+1], negated if signed & sign1.
- Latency: accept at T, `o_ready`/`o_result` registered at T+WIDTH+2 (T+34 for 32).
- END:
  - `o_ready` = 1 and `o_result` is held while `i_start` stays high.
  - When `i_start` falls, go to IDLE next edge with `o_ready` = 0 and `o_result` = 0.
  - `i_annul` in END also returns to IDLE.
- Overflow: signed MIN / −1 → quotient = MIN, remainder = 0 (natural wrap, no trap).
- `i_start` and `i_annul` both high in IDLE: not accepted.

Decomposition:
- Shared package (`defines.svh`/pkg):
  - `div_state_e` enum {IDLE, BYZERO, ON, END}.
  - `DIV_READY`/`DIV_NOT_READY`.
  - `STOP`/`NOSTOP`, reused for `o_stallreq`.
  - `DIV_SIGNED`/`DIV_UNSIGNED`.
- No sub-module needed. The iteration step may optionally live in a combinational `div_step` helper; a single module is preferred.

Test Plan:
- Unsigned 100/7, start at T → `o_stallreq` = 1 from T; at T+34 `o_ready` = 1, result = {0x00000002, 0x0000000E}; `o_stallreq` = 0 in the same cycle.
- Signed −7 (0xFFFFFFF9) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divisor 0 (either mode) → `o_ready` at T+2, result = 0; `o_stallreq` high at T and T+1 only.
- `i_annul` pulsed at T+10 → IDLE at T+11, `o_ready` never asserts. A new request at T+12 completes normally at T+46.
- `i_start` held 5 cycles past `o_ready` → result stable for all 5; drop `i_start` → next cycle `o_ready` = 0, `o_result` = 0. Operands changed during ON → result unaffected.
- `i_rst` asserted at T+20 → next cycle all outputs 0, state IDLE. Unsigned 0xFFFFFFFF/1 afterwards → {0, 0xFFFFFFFF}.
